clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Reconfiguration sequencer for the programmable reference-clock divider.
- Owns the divider's enable and division-ratio controls and changes the ratio only while the divider is disabled.
- Guard intervals are inserted before and after every ratio change so the divided clock never glitches on a switch-over.
- Upstream software/CSR logic issues ratio-change requests over a valid/ready handshake and receives a done pulse on completion.

Parameters:
- DIV_RATIO_WIDTH, 4: width of the ratio fields; must match the divider.
- GUARD_CYCLES, 4: reference cycles spent in each guard interval (DRAIN and SETTLE); legal range >= 1.
- RESET_RATIO, 2: value driven on o_div_ratio out of reset.

Ports:
- i_ref_clk  in  1  reference clock (same clock as the divider).
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  level; 1 = divided clock wanted.
- i_req_valid  in  1  ratio-change request valid.
- i_req_ratio  in  DIV_RATIO_WIDTH  requested ratio.
- o_req_ready  out  1  request accepted when i_req_valid & o_req_ready at a rising edge.
- o_div_ratio  out  DIV_RATIO_WIDTH  ratio driven to the divider.
- o_clk_en  out  1  enable driven to the divider.
- o_busy  out  1  reconfiguration in progress.
- o_done  out  1  one-cycle completion pulse.
- o_bypass  out  1  1 when o_div_ratio < 2 (the divider passes the reference clock through).

Behaviour:
- Registered outputs: all outputs are registered except o_req_ready, o_busy and o_bypass, which are decoded from registered state only.
- Reset values: state OFF; o_div_ratio = RESET_RATIO; o_clk_en = 0; o_done = 0; pending flag = 0; guard counter = 0. Reset mid-sequence aborts immediately, discards any pending ratio and produces no o_done.
- States: OFF, SETTLE, RUN, DRAIN, LOAD.
  - o_req_ready = 1 only in OFF and RUN.
  - o_busy = 1 in DRAIN, LOAD and SETTLE.
  - o_clk_en = 1 only in RUN.
- Guard counter: width clog2(GUARD_CYCLES+1); cleared on entry to DRAIN or SETTLE. The state exits when the count reaches GUARD_CYCLES-1, so the state lasts exactly GUARD_CYCLES cycles.
- OFF:
  - Request accepted → o_div_ratio <= i_req_ratio and o_done = 1 for the following cycle.
  - If i_enable = 1 (with or without a request) → SETTLE, pending = 0.
- SETTLE, exit at guard end:
  - i_enable = 1 → RUN.
  - i_enable = 0 → OFF.
  - If pending = 1, o_done pulses for one cycle coincident with entering RUN/OFF; pending cleared.
  - i_enable falling mid-SETTLE with pending = 0 → OFF at the next edge.
- RUN:
  - i_enable = 0 → OFF at the next edge (o_clk_en low after that edge). A request accepted in the same cycle is loaded directly as in OFF, with o_done pulsing.
  - Otherwise, accepted request with i_req_ratio == o_div_ratio → stay in RUN, o_done pulses next cycle, no enable disturbance.
  - Otherwise, accepted request with a different ratio → latch the pending ratio, pending = 1, go to DRAIN.
- DRAIN (o_clk_en = 0) → LOAD after GUARD_CYCLES cycles.
- LOAD: lasts one cycle; o_div_ratio <= pending ratio; → SETTLE.
- Latency, G = GUARD_CYCLES, differing-ratio request accepted at edge T:
  - o_clk_en falls after edge T.
  - o_div_ratio updates at edge T+G+1.
  - o_clk_en rises and o_done pulses after edge T+2G+1.
  - G = 4 gives 9 cycles with o_clk_en = 0.
- i_enable deasserting during DRAIN/LOAD/SETTLE does not abort the sequence: the ratio is still loaded, the exit goes to OFF, and o_done still pulses.
- Ratios 0 and 1: accepted and loaded like any other value; o_bypass = 1 while loaded; o_clk_en still follows the state.
- Requests while o_req_ready = 0 are ignored; the requester holds i_req_valid. No queueing.

Test Plan:
- Reset then release with i_enable = 0 → o_div_ratio = 2, o_clk_en = 0, o_req_ready = 1, o_done = 0, o_bypass = 0.
- i_enable = 1 from OFF (G = 4) → o_clk_en = 0 for 4 cycles, then 1; o_busy = 1 for exactly those 4 cycles; no o_done.
- In RUN with ratio 2, request ratio 5 accepted at edge T → o_clk_en low after T; o_div_ratio = 5 at T+5; o_clk_en high and a single-cycle o_done after T+9; o_req_ready = 0 from T to T+9.
- In RUN with ratio 5, request 5 → o_done one cycle later; o_clk_en never drops. In OFF, request 1 → o_div_ratio = 1, o_bypass = 1, one-cycle o_done.
- In RUN, request 7, then drop i_enable during DRAIN → o_div_ratio = 7 loaded, FSM ends in OFF with o_clk_en = 0, o_done pulses once at SETTLE exit.
- Assert i_rst_n = 0 mid-SETTLE of a 3→6 change → outputs return to reset values asynchronously; no o_done; o_div_ratio = 2 after release.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
// Reconfiguration sequencer for the programmable reference-clock divider.
// The divider ratio is only ever changed while the divider enable is low.
// Guard intervals (DRAIN before, SETTLE after) surround every ratio change
// so the divided clock cannot glitch on a switch-over.
//
// Request handshake: a request transfers on a rising edge of i_ref_clk when
// both i_req_valid and o_req_ready are 1. The requester holds i_req_valid
// (and i_req_ratio stable) until then. Requests are not queued.
//
// Ports:
//   i_ref_clk     reference clock, shared with the divider
//   i_rst_n       asynchronous active-low reset
//   i_enable      level, 1 = divided clock wanted
//   i_req_valid   ratio-change request valid
//   i_req_ratio   requested ratio
//   o_req_ready   request can be accepted (OFF or RUN)
//   o_div_ratio   ratio driven to the divider (registered)
//   o_clk_en      enable driven to the divider (registered, 1 only in RUN)
//   o_busy        reconfiguration in progress (DRAIN, LOAD, SETTLE)
//   o_done        one-cycle completion pulse (registered)
//   o_bypass      1 when o_div_ratio < 2 (divider passes the clock through)
//   o_dbg_state   current FSM state encoding, for observation only
module clk_div_ctrl #(
    parameter int DIV_RATIO_WIDTH = 4,
    parameter int GUARD_CYCLES    = 4,
    parameter int RESET_RATIO     = 2
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic                       i_req_valid,
    input  logic [DIV_RATIO_WIDTH-1:0] i_req_ratio,
    output logic                       o_req_ready,
    output logic [DIV_RATIO_WIDTH-1:0] o_div_ratio,
    output logic                       o_clk_en,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_bypass,
    output logic [2:0]                 o_dbg_state
);

    localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_LOAD   = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [DIV_RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic [DIV_RATIO_WIDTH-1:0] pend_ratio_q, pend_ratio_d;
    logic                       pending_q, pending_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       clk_en_q, clk_en_d;
    logic                       done_q, done_d;
    logic                       accept;

    assign o_req_ready = (state_q == ST_OFF) || (state_q == ST_RUN);
    assign o_busy      = (state_q == ST_DRAIN) || (state_q == ST_LOAD) ||
                         (state_q == ST_SETTLE);
    assign o_bypass    = (ratio_q < DIV_RATIO_WIDTH'(2));
    assign o_div_ratio = ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_done      = done_q;
    assign o_dbg_state = state_q;

    assign accept = i_req_valid && o_req_ready;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_OFF;
            ratio_q      <= DIV_RATIO_WIDTH'(RESET_RATIO);
            pend_ratio_q <= '0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            clk_en_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ratio_q      <= ratio_d;
            pend_ratio_q <= pend_ratio_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            clk_en_q     <= clk_en_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ratio_d      = ratio_q;
        pend_ratio_d = pend_ratio_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;

        case (state_q)
            ST_OFF: begin
                // Divider is already disabled, so a new ratio loads directly.
                if (accept) begin
                    ratio_d = i_req_ratio;
                    done_d  = 1'b1;
                end
                if (i_enable) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = i_enable ? ST_RUN : ST_OFF;
                    if (pending_q) begin
                        done_d    = 1'b1;
                        pending_d = 1'b0;
                    end
                end else if (!i_enable && !pending_q) begin
                    // Plain power-up settle with nothing to finish: abandon it.
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!i_enable) begin
                    // Divider is being switched off anyway; a same-cycle
                    // request loads as it would in OFF.
                    state_d = ST_OFF;
                    if (accept) begin
                        ratio_d = i_req_ratio;
                        done_d  = 1'b1;
                    end
                end else if (accept) begin
                    if (i_req_ratio == ratio_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_ratio_d = i_req_ratio;
                        pending_d    = 1'b1;
                        state_d      = ST_DRAIN;
                        cnt_d        = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                ratio_d = pend_ratio_q;
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        clk_en_d = (state_d == ST_RUN);
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with GUARD_CYCLES = 4, RESET_RATIO = 2.
module tb_clk_div_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         req_valid;
    logic [W-1:0] req_ratio;
    logic         req_ready;
    logic [W-1:0] div_ratio;
    logic         clk_en;
    logic         busy;
    logic         done;
    logic         bypass;
    logic [2:0]   dbg_state;

    int n_tests  = 0;
    int n_failed = 0;
    int done_cnt;

    clk_div_ctrl #(
        .DIV_RATIO_WIDTH(W),
        .GUARD_CYCLES   (4),
        .RESET_RATIO    (2)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_req_valid(req_valid),
        .i_req_ratio(req_ratio),
        .o_req_ready(req_ready),
        .o_div_ratio(div_ratio),
        .o_clk_en   (clk_en),
        .o_busy     (busy),
        .o_done     (done),
        .o_bypass   (bypass),
        .o_dbg_state(dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Request issued while ready is high; accepted at the next edge.
    task automatic request(input logic [W-1:0] r);
        req_valid = 1'b1;
        req_ratio = r;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = 1'b0;
        req_ratio = '0;
        step();
        step();

        // Reset values
        check("rst_ratio", div_ratio, 2);
        check("rst_clk_en", clk_en, 0);
        check("rst_done", done, 0);
        check("rst_ready", req_ready, 1);
        check("rst_bypass", bypass, 0);
        rst_n = 1'b1;
        step();
        check("rel_ratio", div_ratio, 2);
        check("rel_ready", req_ready, 1);
        check("rel_busy", busy, 0);

        // Enable from OFF: 4 cycles of SETTLE, no done
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("en_busy", busy, 1);
            check("en_clk_en_low", clk_en, 0);
            check("en_no_done", done, 0);
        end
        step();
        check("en_clk_en_high", clk_en, 1);
        check("en_busy_clr", busy, 0);
        check("en_no_done_run", done, 0);

        // RUN ratio 2 -> 5, accepted at edge T
        check("chg_ready_before", req_ready, 1);
        request(4'd5);
        check("chg_clk_en_T", clk_en, 0);
        check("chg_ready_T", req_ready, 0);
        check("chg_ratio_T", div_ratio, 2);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("chg_ratio_mid", div_ratio, (k < 5) ? 2 : 5);
            check("chg_clk_en_mid", clk_en, 0);
            check("chg_ready_mid", req_ready, 0);
            check("chg_done_mid", done, 0);
        end
        step();
        check("chg_clk_en_T9", clk_en, 1);
        check("chg_done_T9", done, 1);
        check("chg_ready_T9", req_ready, 1);
        check("chg_ratio_T9", div_ratio, 5);
        step();
        check("chg_done_T10", done, 0);

        // Same-ratio request in RUN
        request(4'd5);
        check("same_done", done, 1);
        check("same_clk_en", clk_en, 1);
        check("same_busy", busy, 0);
        step();
        check("same_done_clr", done, 0);
        check("same_clk_en2", clk_en, 1);

        // Disable, then bypass ratio in OFF
        enable = 1'b0;
        step();
        check("off_clk_en", clk_en, 0);
        check("off_state", dbg_state, 0);
        request(4'd1);
        check("byp_ratio", div_ratio, 1);
        check("byp_bypass", bypass, 1);
        check("byp_done", done, 1);
        step();
        check("byp_done_clr", done, 0);
        check("byp_bypass_hold", bypass, 1);

        // Back to RUN, request 7, drop enable during DRAIN
        enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("run2_clk_en", clk_en, 1);
        check("run2_bypass", bypass, 1);
        request(4'd7);
        check("dr_state_T", dbg_state, 3);
        step();
        enable = 1'b0;
        done_cnt = 0;
        for (int k = 2; k <= 9; k++) begin
            step();
            if (done) done_cnt++;
            if (k < 9) check("dr_clk_en_mid", clk_en, 0);
        end
        check("dr_done_T9", done, 1);
        check("dr_ratio", div_ratio, 7);
        check("dr_state_off", dbg_state, 0);
        check("dr_clk_en_end", clk_en, 0);
        check("dr_bypass_end", bypass, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("dr_done_count", done_cnt, 1);

        // Reset mid-SETTLE of 3 -> 6
        request(4'd3);
        check("r3_ratio", div_ratio, 3);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("r3_clk_en", clk_en, 1);
        request(4'd6);
        for (int k = 1; k <= 6; k++) step();
        check("mid_state_settle", dbg_state, 1);
        check("mid_ratio6", div_ratio, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ratio", div_ratio, 2);
        check("arst_clk_en", clk_en, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", req_ready, 1);
        enable = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("arst_no_done", done_cnt, 0);
        check("arst_ratio_after", div_ratio, 2);
        check("arst_state_after", dbg_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
